// File: rtl/uartwb_txbuf_if.sv
// Byte-write bus between the UART-to-Wishbone command controller and its transmit buffer.
// The master drives single-cycle strobes; there is no backpressure path.
interface uartwb_txbuf_if;
    logic       wr_en;
    logic [7:0] wr_data;

    modport master (output wr_en, output wr_data);
    modport slave  (input  wr_en, input  wr_data);
endinterface

// File: rtl/uartwb_txbuf.sv
// Transmit buffer: FIFO absorbing byte strobes, drained by an 8N1 UART serializer.
// Define UARTWB_TXBUF_PARITY_EN to insert an even-parity bit (8E1 frames).
module uartwb_txbuf #(
    parameter int CLK_DIV    = 868,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uartwb_txbuf_if.slave         wr,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam int                    DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [15:0]           BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

`ifdef UARTWB_TXBUF_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            mem_q [DEPTH];
`ifdef UARTWB_TXBUF_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic       pop, push, baud_zero;
    logic [7:0] head;

    assign head      = mem_q[rptr_q];
    assign baud_zero = (baud_q == 16'd0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UARTWB_TXBUF_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != S_IDLE) begin
            baud_d = baud_zero ? BAUD_RELOAD : baud_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_zero) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_zero) begin
                    if (bit_q == 3'd7) begin
`ifdef UARTWB_TXBUF_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UARTWB_TXBUF_PARITY_EN
            S_PARITY: begin
                if (baud_zero) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit so queued bytes leave without an idle gap.
                if (baud_zero) begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UARTWB_TXBUF_PARITY_EN
        if (pop) begin
            parity_d = ^head;
        end
`endif

        // A full FIFO still accepts a byte when the serializer frees a slot on the same edge.
        push    = wr.wr_en && ((level_q != LEVEL_FULL) || pop);
        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end

        ovf_d = ovf_q;
        if (wr.wr_en && !push) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
`ifdef UARTWB_TXBUF_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
`ifdef UARTWB_TXBUF_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wr.wr_data;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = (state_q != S_IDLE);
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LEVEL_FULL);
    assign level_o = level_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_uartwb_txbuf.sv
// Directed bench for uartwb_txbuf: drives byte strobes, logs every post-edge output,
// then compares serial frames and status against hand-derived expectations.
module tb_uartwb_txbuf;

    localparam int CLK_DIV    = 4;
    localparam int DEPTH_LOG2 = 4;
`ifdef UARTWB_TXBUF_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FC = FRAME_BITS * CLK_DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ovfClr = 1'b0;
    logic                tx, busy, empty, full, ovf;
    logic [DEPTH_LOG2:0] level;

    uartwb_txbuf_if wrBus ();

    uartwb_txbuf #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr        (wrBus),
        .tx_o      (tx),
        .busy_o    (busy),
        .empty_o   (empty),
        .full_o    (full),
        .level_o   (level),
        .ovf_o     (ovf),
        .ovf_clr_i (ovfClr)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    // Per-cycle log of outputs sampled 1 ns after each rising edge; index c = edge c of a run.
    logic                txLog[$], busyLog[$], emptyLog[$], fullLog[$], ovfLog[$];
    logic [DEPTH_LOG2:0] lvlLog[$];

    // Scheduled writes for the next run: byte wrDat[i] is strobed into edge wrCyc[i].
    int         wrCyc[$];
    logic [7:0] wrDat[$];
    int         clrCyc = -1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n clock edges, driving scheduled strobes and recording outputs after each edge.
    task automatic applyStimulus(input int n);
        txLog.delete(); busyLog.delete(); emptyLog.delete();
        fullLog.delete(); ovfLog.delete(); lvlLog.delete();
        for (int c = 0; c < n; c++) begin
            wrBus.wr_en   = 1'b0;
            wrBus.wr_data = 8'h00;
            ovfClr        = (c == clrCyc);
            foreach (wrCyc[i]) begin
                if (wrCyc[i] == c) begin
                    wrBus.wr_en   = 1'b1;
                    wrBus.wr_data = wrDat[i];
                end
            end
            @(posedge clk);
            #1;
            txLog.push_back(tx);
            busyLog.push_back(busy);
            emptyLog.push_back(empty);
            fullLog.push_back(full);
            ovfLog.push_back(ovf);
            lvlLog.push_back(level);
        end
        wrBus.wr_en = 1'b0;
        ovfClr      = 1'b0;
        wrCyc.delete();
        wrDat.delete();
        clrCyc = -1;
    endtask

    function automatic logic expBit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UARTWB_TXBUF_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [63:0] expFrame(input logic [7:0] b);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < FC; k++) v[k] = expBit(b, k / CLK_DIV);
        return v;
    endfunction

    // Compares back-to-back frames starting at log index start, then the return to idle.
    task automatic checkStream(input string tag, input logic [7:0] bytes[$], input int start);
        logic [63:0] obs;
        int          endIdx;
        for (int f = 0; f < bytes.size(); f++) begin
            obs = '0;
            for (int k = 0; k < FC; k++) obs[k] = txLog[start + f*FC + k];
            checkOutput($sformatf("%s frame%0d", tag, f), obs, expFrame(bytes[f]));
        end
        endIdx = start + bytes.size() * FC;
        checkOutput({tag, " busy in last stop"}, 64'(busyLog[endIdx-1]), 64'd1);
        checkOutput({tag, " busy after frames"}, 64'(busyLog[endIdx]), 64'd0);
        checkOutput({tag, " tx idle after frames"}, 64'(txLog[endIdx]), 64'd1);
        checkOutput({tag, " empty after frames"}, 64'(emptyLog[endIdx]), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bytes[$];
        logic       anyOvf, allIdle;
        int         peak;

        wrBus.wr_en   = 1'b0;
        wrBus.wr_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx", 64'(tx), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset empty", 64'(empty), 64'd1);
        checkOutput("reset full", 64'(full), 64'd0);
        checkOutput("reset level", 64'(level), 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        // Single byte 0xA5: tx falls one edge after the write edge
        wrCyc = '{0};
        wrDat = '{8'hA5};
        applyStimulus(FC + 5);
        checkOutput("A5 tx at write edge", 64'(txLog[0]), 64'd1);
        checkOutput("A5 latency", 64'(txLog[1]), 64'd0);
        bytes = '{8'hA5};
        checkStream("A5", bytes, 1);

        // Five consecutive strobes, back-to-back frames
        bytes = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 5; i++) begin
            wrCyc.push_back(i);
            wrDat.push_back(bytes[i]);
        end
        applyStimulus(5*FC + 5);
        peak = 0;
        anyOvf = 1'b0;
        foreach (lvlLog[i]) begin
            if (int'(lvlLog[i]) > peak) peak = int'(lvlLog[i]);
            anyOvf |= ovfLog[i];
        end
        checkOutput("burst5 level peak", 64'(peak), 64'd4);
        checkOutput("burst5 level at edge4", 64'(lvlLog[4]), 64'd4);
        checkOutput("burst5 ovf", 64'(anyOvf), 64'd0);
        checkStream("burst5", bytes, 1);

        // Eighteen strobes: b0 drains immediately, b1..b16 fill the FIFO, b17 is dropped
        bytes.delete();
        for (int i = 0; i < 18; i++) begin
            wrCyc.push_back(i);
            wrDat.push_back(8'(i*37 + 11));
        end
        for (int i = 0; i < 17; i++) bytes.push_back(8'(i*37 + 11));
        applyStimulus(17*FC + 5);
        checkOutput("ovf18 level full", 64'(lvlLog[16]), 64'd16);
        checkOutput("ovf18 full flag", 64'(fullLog[16]), 64'd1);
        checkOutput("ovf18 ovf before drop", 64'(ovfLog[16]), 64'd0);
        checkOutput("ovf18 ovf after drop", 64'(ovfLog[17]), 64'd1);
        checkOutput("ovf18 level after drop", 64'(lvlLog[17]), 64'd16);
        checkStream("ovf18", bytes, 1);
        clrCyc = 2;
        applyStimulus(4);
        checkOutput("ovf sticky before clear", 64'(ovfLog[1]), 64'd1);
        checkOutput("ovf cleared", 64'(ovfLog[2]), 64'd0);

        // Full FIFO plus a write on the STOP-to-START pop edge: accepted, no overflow
        bytes.delete();
        for (int i = 0; i < 17; i++) begin
            wrCyc.push_back(i);
            wrDat.push_back(8'(8'hC0 ^ 8'(i*5)));
            bytes.push_back(8'(8'hC0 ^ 8'(i*5)));
        end
        wrCyc.push_back(FC + 1);
        wrDat.push_back(8'h5A);
        bytes.push_back(8'h5A);
        applyStimulus(18*FC + 5);
        checkOutput("popwr level before", 64'(lvlLog[FC]), 64'd16);
        checkOutput("popwr level after", 64'(lvlLog[FC+1]), 64'd16);
        checkOutput("popwr full after", 64'(fullLog[FC+1]), 64'd1);
        checkOutput("popwr ovf", 64'(ovfLog[FC+1]), 64'd0);
        checkStream("popwr", bytes, 1);

        // Reset mid-DATA with three bytes queued; tx is low (bit1 of 0x01) when reset hits
        wrCyc = '{0, 1, 2, 3};
        wrDat = '{8'h01, 8'h22, 8'h33, 8'h44};
        applyStimulus(12);
        checkOutput("midrst tx before reset", 64'(txLog[11]), 64'd0);
        checkOutput("midrst level before reset", 64'(lvlLog[11]), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst tx", 64'(tx), 64'd1);
        checkOutput("midrst level", 64'(level), 64'd0);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        checkOutput("midrst empty", 64'(empty), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(3*FC);
        allIdle = 1'b1;
        foreach (txLog[i]) allIdle &= txLog[i] & ~busyLog[i];
        checkOutput("postrst quiet", 64'(allIdle), 64'd1);
        wrCyc = '{0};
        wrDat = '{8'h3C};
        applyStimulus(FC + 5);
        bytes = '{8'h3C};
        checkStream("postrst", bytes, 1);

`ifdef UARTWB_TXBUF_PARITY_EN
        // Even parity: 0x07 has three ones, 0x03 has two
        wrCyc = '{0};
        wrDat = '{8'h07};
        applyStimulus(FC + 5);
        checkOutput("par07 parity bit", 64'(txLog[1 + 9*CLK_DIV]), 64'd1);
        bytes = '{8'h07};
        checkStream("par07", bytes, 1);
        wrCyc = '{0};
        wrDat = '{8'h03};
        applyStimulus(FC + 5);
        checkOutput("par03 parity bit", 64'(txLog[1 + 9*CLK_DIV]), 64'd0);
        bytes = '{8'h03};
        checkStream("par03", bytes, 1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
